// File: rtl/qam16_upsample_mapper_if.sv
// Symbol/sample bundle between the upstream symbol source, the QAM16 mapper and its sink.
// Master is the mapper side; slave is the side that paces and consumes it.
interface qam16_upsample_mapper_if #(
  parameter int UPSAMPLE = 4
);
  localparam int PW = $clog2(UPSAMPLE);

  logic                clk_en;
  logic                tx_en;
  logic [3:0]          sym_in;
  logic                sym_req;
  logic signed [17:0]  i_out;
  logic signed [17:0]  q_out;
  logic                sym_valid;
  logic [PW-1:0]       phase;
  logic [15:0]         sym_count;

  modport master (
    input  clk_en, tx_en, sym_in,
    output sym_req, i_out, q_out, sym_valid, phase, sym_count
  );

  modport slave (
    output clk_en, tx_en, sym_in,
    input  sym_req, i_out, q_out, sym_valid, phase, sym_count
  );
endinterface

// File: rtl/qam16_upsample_mapper.sv
// Gray QAM16 mapper with UPSAMPLE-fold impulse-train or sample-and-hold upsampling; 1-cycle latency.
// No backpressure: paced by clk_en, muted by tx_en; sym_req strobes the upstream source once per symbol.
module qam16_upsample_mapper #(
  parameter int                 UPSAMPLE   = 4,
  parameter logic signed [17:0] LEVEL_1    = 18'sd8192,
  parameter bit                 ZERO_STUFF = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  qam16_upsample_mapper_if.master    bus
);
  localparam int                 PW      = $clog2(UPSAMPLE);
  localparam logic [PW-1:0]      PH_LAST = PW'(UPSAMPLE - 1);
  localparam logic signed [17:0] LEVEL_3 = 18'(3 * LEVEL_1);

  if (UPSAMPLE < 2 || UPSAMPLE > 16 || (UPSAMPLE & (UPSAMPLE - 1)) != 0) begin : g_bad_upsample
    $error("UPSAMPLE must be a power of two in 2..16");
  end

  logic [PW-1:0]      phase_q;
  logic signed [17:0] i_q;
  logic signed [17:0] q_q;
  logic               sym_valid_q;
  logic [15:0]        sym_count_q;

  // Gray 4-ASK per axis: adjacent levels differ in one bit.
  function automatic logic signed [17:0] map_axis(input logic [1:0] b);
    logic signed [17:0] v;
    case (b)
      2'b00:   v = -LEVEL_3;
      2'b01:   v = -LEVEL_1;
      2'b11:   v = LEVEL_1;
      default: v = LEVEL_3;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= '0;
      i_q         <= '0;
      q_q         <= '0;
      sym_valid_q <= 1'b0;
      sym_count_q <= '0;
    end else if (bus.clk_en) begin
      if (!bus.tx_en) begin
        phase_q     <= '0;
        i_q         <= '0;
        q_q         <= '0;
        sym_valid_q <= 1'b0;
      end else begin
        // Power-of-two UPSAMPLE lets the counter wrap on its own.
        phase_q <= phase_q + PW'(1);
        if (phase_q == '0) begin
          i_q         <= map_axis(bus.sym_in[3:2]);
          q_q         <= map_axis(bus.sym_in[1:0]);
          sym_valid_q <= 1'b1;
          sym_count_q <= sym_count_q + 16'd1;
        end else begin
          sym_valid_q <= 1'b0;
          if (ZERO_STUFF) begin
            i_q <= '0;
            q_q <= '0;
          end
        end
      end
    end
  end

  // Upstream advances on the last phase so its next symbol is ready for the phase-0 edge.
  assign bus.sym_req   = bus.clk_en & bus.tx_en & (phase_q == PH_LAST) & ~reset;
  assign bus.i_out     = i_q;
  assign bus.q_out     = q_q;
  assign bus.sym_valid = sym_valid_q;
  assign bus.phase     = phase_q;
  assign bus.sym_count = sym_count_q;
endmodule

// File: tb/tb_qam16_upsample_mapper.sv
// Directed bench: impulse-train instance plus a sample-and-hold twin driven with identical stimulus.
module tb_qam16_upsample_mapper;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  qam16_upsample_mapper_if #(.UPSAMPLE(4)) mif ();
  qam16_upsample_mapper_if #(.UPSAMPLE(4)) hif ();

  qam16_upsample_mapper #(.UPSAMPLE(4), .LEVEL_1(18'sd8192), .ZERO_STUFF(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(mif)
  );
  qam16_upsample_mapper #(.UPSAMPLE(4), .LEVEL_1(18'sd8192), .ZERO_STUFF(1'b0)) dut_h (
    .clk(clk), .reset(reset), .bus(hif)
  );

  int n_checks = 0;
  int n_pass   = 0;
  // Gray table indexed by the two axis bits: 00, 01, 10, 11.
  int amap [4] = '{-24576, -8192, 24576, 8192};
  logic       auto_up = 1'b0;
  logic [3:0] up;
  logic [3:0] exp_sym;
  int         exp_ph;
  logic       en;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  task automatic drive(input logic c_en, input logic t_en, input logic [3:0] s);
    mif.clk_en = c_en; hif.clk_en = c_en;
    mif.tx_en  = t_en; hif.tx_en  = t_en;
    mif.sym_in = s;    hif.sym_in = s;
  endtask

  task automatic tick();
    logic req;
    req = mif.sym_req;
    @(posedge clk);
    #1;
    if (auto_up && req) begin
      up = lfsr_next(up);
      mif.sym_in = up;
      hif.sym_in = up;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b1, 4'b0111);
    #1;
    chk("rst_req", mif.sym_req, 0);
    tick();
    chk("rst_i", mif.i_out, 0);
    chk("rst_q", mif.q_out, 0);
    chk("rst_vld", mif.sym_valid, 0);
    chk("rst_phase", mif.phase, 0);
    chk("rst_cnt", mif.sym_count, 0);

    // Constant symbol 0111 -> I=-L, Q=+L on samples 0,4,8.
    reset = 1'b0;
    for (int s = 0; s < 12; s++) begin
      #1 chk("t1_req", mif.sym_req, (s % 4) == 3);
      tick();
      chk("t1_i", mif.i_out, (s % 4 == 0) ? -8192 : 0);
      chk("t1_q", mif.q_out, (s % 4 == 0) ? 8192 : 0);
      chk("t1_vld", mif.sym_valid, (s % 4) == 0);
      chk("t1_phase", mif.phase, (s + 1) % 4);
      chk("t1_hold_i", hif.i_out, -8192);
      chk("t1_hold_vld", hif.sym_valid, (s % 4) == 0);
    end
    chk("t1_cnt", mif.sym_count, 3);

    // Every symbol value, one per symbol period.
    for (int v = 0; v < 16; v++) begin
      drive(1'b1, 1'b1, 4'(v));
      for (int p = 0; p < 4; p++) begin
        #1 chk("t2_req", mif.sym_req, p == 3);
        tick();
        if (p == 0) begin
          chk("t2_i", mif.i_out, amap[v >> 2]);
          chk("t2_q", mif.q_out, amap[v & 3]);
          chk("t2_vld", mif.sym_valid, 1);
          chk("t2_cnt", mif.sym_count, 4 + v);
        end else if (p == 1) begin
          chk("t2_zs_i", mif.i_out, 0);
          chk("t2_hold_i", hif.i_out, amap[v >> 2]);
          chk("t2_hold_q", hif.q_out, amap[v & 3]);
          chk("t2_hold_vld", hif.sym_valid, 0);
        end
      end
    end

    // clk_en 1 of 3 with an LFSR upstream advanced only by sym_req.
    up = 4'b1001;
    exp_sym = up;
    exp_ph = 0;
    drive(1'b1, 1'b1, up);
    auto_up = 1'b1;
    for (int c = 0; c < 36; c++) begin
      en = (c % 3) == 0;
      mif.clk_en = en; hif.clk_en = en;
      #1 chk("t3_req", mif.sym_req, en && exp_ph == 3);
      tick();
      if (en) begin
        if (exp_ph == 0) begin
          chk("t3_i", mif.i_out, amap[exp_sym[3:2]]);
          chk("t3_q", mif.q_out, amap[exp_sym[1:0]]);
          chk("t3_vld", mif.sym_valid, 1);
          exp_sym = lfsr_next(exp_sym);
        end
        exp_ph = (exp_ph + 1) % 4;
      end
      chk("t3_phase", mif.phase, exp_ph);
    end
    auto_up = 1'b0;
    chk("t3_cnt", mif.sym_count, 22);

    // tx_en dropped at phase 2, then raised with the upstream symbol unchanged.
    drive(1'b1, 1'b1, 4'b1010);
    tick();
    tick();
    chk("t4_phase2", mif.phase, 2);
    mif.tx_en = 1'b0; hif.tx_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1 chk("t4_off_req", mif.sym_req, 0);
      tick();
      chk("t4_off_phase", mif.phase, 0);
      chk("t4_off_i", mif.i_out, 0);
      chk("t4_off_hold_q", hif.q_out, 0);
      chk("t4_off_vld", hif.sym_valid, 0);
      chk("t4_off_cnt", mif.sym_count, 23);
    end
    mif.tx_en = 1'b1; hif.tx_en = 1'b1;
    #1 chk("t4_on_req", mif.sym_req, 0);
    tick();
    chk("t4_on_i", mif.i_out, 24576);
    chk("t4_on_q", mif.q_out, 24576);
    chk("t4_on_vld", mif.sym_valid, 1);
    chk("t4_on_cnt", mif.sym_count, 24);
    tick();
    tick();
    #1 chk("t4_on_req3", mif.sym_req, 1);
    tick();

    // Reset at phase 2 abandons the symbol.
    drive(1'b1, 1'b1, 4'b0000);
    tick();
    tick();
    chk("t5_hold_i", hif.i_out, -24576);
    reset = 1'b1;
    #1 chk("t5_req", mif.sym_req, 0);
    tick();
    chk("t5_phase", mif.phase, 0);
    chk("t5_i", mif.i_out, 0);
    chk("t5_hold_i0", hif.i_out, 0);
    chk("t5_hold_vld", hif.sym_valid, 0);
    chk("t5_cnt", mif.sym_count, 0);
    reset = 1'b0;
    drive(1'b1, 1'b1, 4'b1101);
    tick();
    chk("t5_i1", mif.i_out, 8192);
    chk("t5_q1", mif.q_out, -8192);
    chk("t5_cnt1", mif.sym_count, 1);

    // Counter preset close to full scale to exercise the wrap.
    mif.clk_en = 1'b0; hif.clk_en = 1'b0;
    force dut.sym_count_q = 16'hFFFE;
    #1;
    release dut.sym_count_q;
    mif.clk_en = 1'b1; hif.clk_en = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_pre", mif.sym_count, 16'hFFFE);
    tick();
    chk("t6_ffff", mif.sym_count, 16'hFFFF);
    for (int k = 0; k < 4; k++) tick();
    chk("t6_wrap", mif.sym_count, 0);
    tick();
    tick();
    chk("t6_phase3", mif.phase, 3);
    reset = 1'b1;
    #1 chk("t6_rst_req", mif.sym_req, 0);
    tick();
    chk("t6_rst_phase", mif.phase, 0);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/qam16_upsample_mapper.md
QAM16_UPSAMPLE_MAPPER -- requirements
Module: qam16_upsample_mapper

Interface
REQ-001 Parameter UPSAMPLE, default 4, samples per symbol; SHALL be a power of two in 2..16.
REQ-002 Parameter LEVEL_1, default 18'sd8192, magnitude of the inner constellation level; outer level SHALL be 3*LEVEL_1.
REQ-003 Parameter ZERO_STUFF, default 1; 1 = impulse train (zeros between symbols), 0 = sample-and-hold.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 clk_en  input  1  sample-rate enable; state advances only on edges where clk_en=1.
REQ-007 tx_en  input  1  transmit enable; 0 mutes output and parks the phase counter.
REQ-008 sym_in  input  4  data symbol from the upstream LFSR; [3:2] = I bits, [1:0] = Q bits.
REQ-009 sym_req  output  1  combinational strobe; drives the upstream LFSR clk_en so it advances once per symbol.
REQ-010 i_out  output  18  signed in-phase sample.
REQ-011 q_out  output  18  signed quadrature sample.
REQ-012 sym_valid  output  1  high for the sample that carries a new symbol.
REQ-013 phase  output  log2(UPSAMPLE)  current sample phase within the symbol.
REQ-014 sym_count  output  16  count of symbols emitted since reset.

Function
REQ-015 Gray 4-ASK mapping per axis SHALL be: 00 -> -3*LEVEL_1, 01 -> -LEVEL_1, 11 -> +LEVEL_1, 10 -> +3*LEVEL_1.
REQ-016 The phase counter SHALL increment on each edge with clk_en=1 and tx_en=1, wrapping from UPSAMPLE-1 to 0.
REQ-017 sym_req SHALL equal clk_en & tx_en & (phase == UPSAMPLE-1) & ~reset, one clk wide per symbol.
REQ-018 On an edge with clk_en=1, tx_en=1 and phase=0, the block SHALL register mapped I/Q of sym_in into i_out/q_out, set sym_valid=1, and increment sym_count.
REQ-019 On an edge with clk_en=1, tx_en=1 and phase!=0: sym_valid SHALL go 0; i_out/q_out SHALL go 0 if ZERO_STUFF=1, else hold.
REQ-020 Latency: sym_in sampled at a phase-0 edge SHALL appear on i_out/q_out immediately after that edge (1 register stage).
REQ-021 On edges with clk_en=0, all registers (phase, i_out, q_out, sym_valid, sym_count) SHALL hold.
REQ-022 On an edge with clk_en=1 and tx_en=0: phase SHALL go 0; i_out, q_out and sym_valid SHALL go 0; sym_count SHALL hold.
REQ-023 After tx_en rises, the first clk_en edge SHALL be phase 0 and emit the current sym_in; the upstream symbol is not advanced beforehand.
REQ-024 sym_count SHALL wrap from 16'hFFFF to 0 without flag.
REQ-025 A symbol SHALL never be emitted twice; the upstream SHALL advance exactly once between consecutive sym_valid pulses.

Reset
REQ-026 While reset=1 at a rising edge, phase, i_out, q_out, sym_valid and sym_count SHALL go 0, overriding clk_en and tx_en.
REQ-027 Reset mid-symbol SHALL abandon the symbol; the next emitted symbol SHALL be at phase 0 after release.
REQ-028 sym_req SHALL be 0 whenever reset=1.

Verification
REQ-029 Reset, clk_en=1, tx_en=1, sym_in=4'b0111 held, UPSAMPLE=4 -> i_out=-8192, q_out=+8192, sym_valid=1 on samples 0,4,8; zeros elsewhere; sym_req high at phase 3 only.
REQ-030 Drive all 16 sym_in values, one per symbol -> i_out/q_out match the REQ-015 Gray table; sym_count increments by 1 per symbol.
REQ-031 clk_en high 1 of 3 cycles -> outputs/phase change only on enabled edges; sym_req pulses once per 4 enabled edges; no symbol skipped or repeated against an upstream LFSR model.
REQ-032 tx_en dropped at phase 2, then raised -> outputs 0 while low, sym_count frozen, first symbol after raise emitted at phase 0 with no extra sym_req.
REQ-033 ZERO_STUFF=0 -> i_out/q_out hold symbol value across all 4 phases; sym_valid still 1 only at phase 0.
REQ-034 reset asserted at phase 2 with clk_en=1 -> next edge all outputs 0, phase 0; sym_count preset near 16'hFFFF in a separate run wraps to 0.
